vga_scanout: RTL

- Downstream consumer of the gpu rasteriser's framebuffer writes.
- Sweeps a 640x480 double-buffered framebuffer of 6-bit RRGGBB pixels and drives VGA timing and 2-bit-per-channel colour.
- Owns front/back buffer selection: the gpu draws into the back buffer, pulses swap_req when done, and this block flips buffers at the next vertical blank.

---
 rtl/vga_scanout.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/vga_scanout.sv
// VGA scan-out of a double-buffered 640x480 RRGGBB framebuffer, with buffer flips taken at vertical blank.
// Latency: the framebuffer address follows the counters; sync/active/colour outputs are RD_LAT clocks behind, aligned with fb_din.
// Backpressure: none. The raster runs freely and fb_din must return data exactly RD_LAT clocks after fb_addr.
module vga_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int RD_LAT   = 1      // legal range 1..3
) (
    input  logic        clk,
    input  logic        reset,       // asynchronous, active-low
    output logic [18:0] fb_addr,
    output logic        fb_sel,
    input  logic [5:0]  fb_din,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic        hsync,
    output logic        vsync,
    output logic [1:0]  red,
    output logic [1:0]  green,
    output logic [1:0]  blue,
    output logic        active,
    output logic        frame_start
);

    // Raster geometry
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);

    localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [VW-1:0] V_LAST = VW'(VT - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SWAP = VW'(V_ACTIVE - 1);  // last visible line; its end is the flip point
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    // One pipeline beat of the raster-derived controls (sync outputs are active-low)
    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic act;
        logic fs;
    } beat_t;

    localparam beat_t BEAT_RST = '{hs_n: 1'b1, vs_n: 1'b1, act: 1'b0, fs: 1'b0};

    logic [HW-1:0] hcount_q, hcount_d;
    logic [VW-1:0] vcount_q, vcount_d;
    logic [18:0]   fb_addr_q, fb_addr_d;
    logic          fb_sel_q, fb_sel_d;
    logic          pending_q, pending_d;
    logic          swap_ack_q, swap_ack_d;
    beat_t         beat_d;
    beat_t         pipe_q [RD_LAT];

    logic h_wrap;
    logic v_wrap;
    logic raw_active;
    logic swap_pt;

    // Raster position decode for the current cycle
    always_comb begin
        h_wrap     = (hcount_q == H_LAST);
        v_wrap     = (vcount_q == V_LAST);
        raw_active = (hcount_q < H_ACT) && (vcount_q < V_ACT);
        // Clock on which the counters move to (0, V_ACTIVE): first blank line, safe to flip.
        swap_pt    = h_wrap && (vcount_q == V_SWAP);
    end

    // Next raster position: hcount wraps each line, vcount steps on the wrap
    always_comb begin
        hcount_d = h_wrap ? '0 : hcount_q + HW'(1);
        vcount_d = vcount_q;
        if (h_wrap) begin
            vcount_d = v_wrap ? '0 : vcount_q + VW'(1);
        end
    end

    // Linear read address: steps once per visible pixel, so the value at (x,y) is H_ACTIVE*y+x
    // without a multiplier. During blanking it parks on the next line's first address.
    always_comb begin
        fb_addr_d = fb_addr_q;
        if (h_wrap && v_wrap) begin
            fb_addr_d = '0;
        end else if (raw_active) begin
            fb_addr_d = fb_addr_q + 19'd1;
        end
    end

    // Buffer-flip handshake: requests collect in pending and are consumed only at the flip point,
    // so any number of requests in a frame gives one flip. A request on the flip clock itself counts.
    always_comb begin
        fb_sel_d   = fb_sel_q;
        swap_ack_d = 1'b0;
        pending_d  = pending_q | swap_req;
        if (swap_pt && (pending_q || swap_req)) begin
            fb_sel_d   = ~fb_sel_q;
            swap_ack_d = 1'b1;
            pending_d  = 1'b0;
        end
    end

    // Raw, undelayed controls for the current raster position
    always_comb begin
        beat_d      = BEAT_RST;
        beat_d.hs_n = !((hcount_q >= HS_BEG) && (hcount_q < HS_END));
        beat_d.vs_n = !((vcount_q >= VS_BEG) && (vcount_q < VS_END));
        beat_d.act  = raw_active;
        beat_d.fs   = (hcount_q == '0) && (vcount_q == '0);
    end

    // Raster, address and buffer-select state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcount_q   <= '0;
            vcount_q   <= '0;
            fb_addr_q  <= '0;
            fb_sel_q   <= 1'b0;
            pending_q  <= 1'b0;
            swap_ack_q <= 1'b0;
        end else begin
            hcount_q   <= hcount_d;
            vcount_q   <= vcount_d;
            fb_addr_q  <= fb_addr_d;
            fb_sel_q   <= fb_sel_d;
            pending_q  <= pending_d;
            swap_ack_q <= swap_ack_d;
        end
    end

    // Delay line matching the framebuffer read latency, so controls line up with fb_din
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= BEAT_RST;
            end
        end else begin
            pipe_q[0] <= beat_d;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign fb_addr     = fb_addr_q;
    assign fb_sel      = fb_sel_q;
    assign swap_ack    = swap_ack_q;
    assign hsync       = pipe_q[RD_LAT-1].hs_n;
    assign vsync       = pipe_q[RD_LAT-1].vs_n;
    assign active      = pipe_q[RD_LAT-1].act;
    assign frame_start = pipe_q[RD_LAT-1].fs;

    // Colour is forced to black outside the visible window, whatever the memory returns
    assign {red, green, blue} = pipe_q[RD_LAT-1].act ? fb_din : 6'd0;

endmodule
